// File: rtl/demorgan_sweep_checker_if.sv
// Bundles the request/result signals of demorgan_sweep_checker.
// master: the requester drives start/mode/inj_en/inj_vec and observes the results.
// slave : the checker samples the request side and drives the results.
//   start          sweep request, sampled only while idle
//   mode           0 = type 1, 1 = type 2; captured on accepted start
//   inj_en/inj_vec fault injection on d_direct at one vector; captured on accepted start
//   busy           high while sweeping
//   valid          vec_out/d_direct/d_dual hold a swept vector
//   done           one-cycle pulse at sweep completion
//   pass           last completed sweep had zero mismatches
//   mismatch_cnt   mismatching vectors in the current or last sweep
//   first_fail_vec first mismatching vector, 0 if none
interface demorgan_sweep_checker_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned CNT_W = N + 1;

    logic             start;
    logic             mode;
    logic             inj_en;
    logic [N-1:0]     inj_vec;
    logic             busy;
    logic             valid;
    logic [N-1:0]     vec_out;
    logic             d_direct;
    logic             d_dual;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [N-1:0]     first_fail_vec;

    modport master (
        output start, mode, inj_en, inj_vec,
        input  busy, valid, vec_out, d_direct, d_dual, done, pass,
               mismatch_cnt, first_fail_vec
    );

    modport slave (
        input  start, mode, inj_en, inj_vec,
        output busy, valid, vec_out, d_direct, d_dual, done, pass,
               mismatch_cnt, first_fail_vec
    );
endinterface

// File: rtl/demorgan_sweep_checker.sv
// Sweeps all 2^N input vectors of the N-input De Morgan pair (type 1 / type 2),
// registering the direct and dual forms per vector and accumulating a mismatch
// count, the first failing vector and a pass flag.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset (release is expected to be synchronised upstream)
//   bus   demorgan_sweep_checker_if.slave request/result bundle
module demorgan_sweep_checker #(
    parameter int unsigned N = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    demorgan_sweep_checker_if.slave  bus
);
    localparam int unsigned CNT_W    = N + 1;
    localparam logic [N-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             inj_en_q, inj_en_d;
    logic [N-1:0]     inj_vec_q, inj_vec_d;
    logic             fail_q, fail_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     vec_out_q, vec_out_d;
    logic             d_direct_q, d_direct_d;
    logic             d_dual_q, d_dual_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic [N-1:0]     first_fail_vec_q, first_fail_vec_d;

    logic [N-2:0]     p_c;
    logic             l_c;
    logic             direct_raw_c;
    logic             direct_c;
    logic             dual_c;
    logic             mismatch_c;

    // Evaluate both forms for the current counter value; P = low N-1 bits, L = top bit.
    always_comb begin
        p_c = cnt_q[N-2:0];
        l_c = cnt_q[N-1];
        if (!mode_q) begin
            direct_raw_c = (|(~p_c)) & ~l_c;
            dual_c       = ~((&p_c) | l_c);
        end else begin
            direct_raw_c = (&(~p_c)) | ~l_c;
            dual_c       = ~((|p_c) & l_c);
        end
        direct_c   = direct_raw_c ^ (inj_en_q && (cnt_q == inj_vec_q));
        mismatch_c = direct_c ^ dual_c;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        mode_d           = mode_q;
        inj_en_d         = inj_en_q;
        inj_vec_d        = inj_vec_q;
        fail_d           = fail_q;
        busy_d           = busy_q;
        valid_d          = valid_q;
        vec_out_d        = vec_out_q;
        d_direct_d       = d_direct_q;
        d_dual_d         = d_dual_q;
        done_d           = 1'b0;
        pass_d           = pass_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        first_fail_vec_d = first_fail_vec_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d          = SWEEP;
                    mode_d           = bus.mode;
                    inj_en_d         = bus.inj_en;
                    inj_vec_d        = bus.inj_vec;
                    cnt_d            = '0;
                    mismatch_cnt_d   = '0;
                    first_fail_vec_d = '0;
                    pass_d           = 1'b0;
                    fail_d           = 1'b0;
                    busy_d           = 1'b1;
                end
            end
            SWEEP: begin
                vec_out_d  = cnt_q;
                d_direct_d = direct_c;
                d_dual_d   = dual_c;
                valid_d    = 1'b1;
                if (mismatch_c) begin
                    mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
                    if (!fail_q) begin
                        first_fail_vec_d = cnt_q;
                        fail_d           = 1'b1;
                    end
                end
                cnt_d = cnt_q + N'(1);
                if (cnt_q == LAST_VEC) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = ~fail_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            mode_q           <= 1'b0;
            inj_en_q         <= 1'b0;
            inj_vec_q        <= '0;
            fail_q           <= 1'b0;
            busy_q           <= 1'b0;
            valid_q          <= 1'b0;
            vec_out_q        <= '0;
            d_direct_q       <= 1'b0;
            d_dual_q         <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            mismatch_cnt_q   <= '0;
            first_fail_vec_q <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            mode_q           <= mode_d;
            inj_en_q         <= inj_en_d;
            inj_vec_q        <= inj_vec_d;
            fail_q           <= fail_d;
            busy_q           <= busy_d;
            valid_q          <= valid_d;
            vec_out_q        <= vec_out_d;
            d_direct_q       <= d_direct_d;
            d_dual_q         <= d_dual_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.valid          = valid_q;
    assign bus.vec_out        = vec_out_q;
    assign bus.d_direct       = d_direct_q;
    assign bus.d_dual         = d_dual_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_cnt   = mismatch_cnt_q;
    assign bus.first_fail_vec = first_fail_vec_q;
endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Directed bench for demorgan_sweep_checker: an N=3 and an N=4 instance share
// clk/rst_n. Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_demorgan_sweep_checker;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demorgan_sweep_checker_if #(.N(3)) if3 ();
    demorgan_sweep_checker_if #(.N(4)) if4 ();

    demorgan_sweep_checker #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    demorgan_sweep_checker #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full N=3 sweep from IDLE; ed/eu hold expected d_direct/d_dual, bit i = vector i.
    task automatic run_sweep3(input string name, input logic m, input logic ie,
                              input logic [2:0] iv, input logic [7:0] ed, input logic [7:0] eu,
                              input logic [3:0] ecnt, input logic [2:0] effv, input logic ep);
        if3.start = 1'b1; if3.mode = m; if3.inj_en = ie; if3.inj_vec = iv;
        @(posedge clk); #1;
        if3.start = 1'b0;
        checks++;
        if ({if3.busy, if3.valid, if3.done} !== 3'b100) begin
            errors++; $display("FAIL %s accept busy/valid/done: got %b want 100", name, {if3.busy, if3.valid, if3.done});
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({if3.valid, if3.vec_out, if3.d_direct, if3.d_dual, if3.done} !== {1'b1, 3'(i), ed[i], eu[i], 1'b0}) begin
                errors++;
                $display("FAIL %s vec%0d valid/vec/dir/dual/done: got %b want %b", name, i,
                         {if3.valid, if3.vec_out, if3.d_direct, if3.d_dual, if3.done}, {1'b1, 3'(i), ed[i], eu[i], 1'b0});
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({if3.done, if3.valid, if3.busy} !== 3'b100) begin
            errors++; $display("FAIL %s done cycle done/valid/busy: got %b want 100", name, {if3.done, if3.valid, if3.busy});
        end
        checks++;
        if ({if3.pass, if3.mismatch_cnt, if3.first_fail_vec} !== {ep, ecnt, effv}) begin
            errors++; $display("FAIL %s results pass/cnt/ffv: got %b want %b", name,
                               {if3.pass, if3.mismatch_cnt, if3.first_fail_vec}, {ep, ecnt, effv});
        end
        @(posedge clk); #1;
        checks++;
        if (if3.done !== 1'b0) begin
            errors++; $display("FAIL %s done pulse width: got %b want 0", name, if3.done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if3.start = 1'b0; if3.mode = 1'b0; if3.inj_en = 1'b0; if3.inj_vec = '0;
        if4.start = 1'b0; if4.mode = 1'b0; if4.inj_en = 1'b0; if4.inj_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if3.busy, if3.valid, if3.vec_out, if3.d_direct, if3.d_dual, if3.done, if3.pass, if3.mismatch_cnt, if3.first_fail_vec} !== '0) begin
            errors++; $display("FAIL reset n3 outputs: got %b want 0",
                               {if3.busy, if3.valid, if3.vec_out, if3.d_direct, if3.d_dual, if3.done, if3.pass, if3.mismatch_cnt, if3.first_fail_vec});
        end
        checks++;
        if ({if4.busy, if4.valid, if4.vec_out, if4.d_direct, if4.d_dual, if4.done, if4.pass, if4.mismatch_cnt, if4.first_fail_vec} !== '0) begin
            errors++; $display("FAIL reset n4 outputs: got %b want 0",
                               {if4.busy, if4.valid, if4.vec_out, if4.d_direct, if4.d_dual, if4.done, if4.pass, if4.mismatch_cnt, if4.first_fail_vec});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({if3.busy, if3.valid, if3.done} !== 3'b000) begin
            errors++; $display("FAIL reset idle after release: got %b want 000", {if3.busy, if3.valid, if3.done});
        end
    endtask

    task automatic test_type1();
        run_sweep3("type1", 1'b0, 1'b0, 3'd0, 8'b0000_0111, 8'b0000_0111, 4'd0, 3'd0, 1'b1);
    endtask

    task automatic test_type2();
        run_sweep3("type2", 1'b1, 1'b0, 3'd0, 8'b0001_1111, 8'b0001_1111, 4'd0, 3'd0, 1'b1);
    endtask

    task automatic test_inject();
        run_sweep3("inject5", 1'b0, 1'b1, 3'd5, 8'b0010_0111, 8'b0000_0111, 4'd1, 3'd5, 1'b0);
    endtask

    // Re-pulse start and flip mode mid-sweep: sequence must stay type 1, one done only.
    task automatic test_restart_ignored();
        logic [7:0] ev;
        int         dones;
        ev = 8'b0000_0111;
        dones = 0;
        if3.start = 1'b1; if3.mode = 1'b0; if3.inj_en = 1'b0; if3.inj_vec = '0;
        @(posedge clk); #1;
        if3.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (if3.done === 1'b1) dones++;
            checks++;
            if ({if3.valid, if3.vec_out, if3.d_direct, if3.d_dual} !== {1'b1, 3'(i), ev[i], ev[i]}) begin
                errors++; $display("FAIL restart_ignored vec%0d: got %b want %b", i,
                                   {if3.valid, if3.vec_out, if3.d_direct, if3.d_dual}, {1'b1, 3'(i), ev[i], ev[i]});
            end
            if (i == 2) begin
                if3.start = 1'b1; if3.mode = 1'b1;
            end else begin
                if3.start = 1'b0;
            end
        end
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (if3.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL restart_ignored done pulses: got %0d want 1", dones);
        end
        checks++;
        if ({if3.busy, if3.valid, if3.pass} !== 3'b001) begin
            errors++; $display("FAIL restart_ignored final busy/valid/pass: got %b want 001", {if3.busy, if3.valid, if3.pass});
        end
        if3.mode = 1'b0;
    endtask

    // Reset at vec_out=3 of an injected sweep aborts and clears everything.
    task automatic test_reset_mid();
        int dones;
        dones = 0;
        if3.start = 1'b1; if3.mode = 1'b0; if3.inj_en = 1'b1; if3.inj_vec = 3'd1;
        @(posedge clk); #1;
        if3.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({if3.vec_out, if3.mismatch_cnt, if3.first_fail_vec} !== {3'd3, 4'd1, 3'd1}) begin
            errors++; $display("FAIL reset_mid pre-reset vec/cnt/ffv: got %b want %b",
                               {if3.vec_out, if3.mismatch_cnt, if3.first_fail_vec}, {3'd3, 4'd1, 3'd1});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if3.busy, if3.valid, if3.vec_out, if3.d_direct, if3.d_dual, if3.done, if3.pass, if3.mismatch_cnt, if3.first_fail_vec} !== '0) begin
            errors++; $display("FAIL reset_mid outputs: got %b want 0",
                               {if3.busy, if3.valid, if3.vec_out, if3.d_direct, if3.d_dual, if3.done, if3.pass, if3.mismatch_cnt, if3.first_fail_vec});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        if3.inj_en = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (if3.done === 1'b1 || if3.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL reset_mid activity after abort: got %0d want 0", dones);
        end
        run_sweep3("after_reset", 1'b0, 1'b0, 3'd0, 8'b0000_0111, 8'b0000_0111, 4'd0, 3'd0, 1'b1);
    endtask

    // start held high relaunches on the edge after done.
    task automatic test_back_to_back();
        logic [7:0] ev;
        ev = 8'b0001_1111;
        if3.start = 1'b1; if3.mode = 1'b1; if3.inj_en = 1'b0; if3.inj_vec = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({if3.valid, if3.vec_out, if3.d_direct} !== {1'b1, 3'(i), ev[i]}) begin
                errors++; $display("FAIL b2b first vec%0d: got %b want %b", i,
                                   {if3.valid, if3.vec_out, if3.d_direct}, {1'b1, 3'(i), ev[i]});
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({if3.done, if3.busy, if3.pass} !== 3'b101) begin
            errors++; $display("FAIL b2b first done/busy/pass: got %b want 101", {if3.done, if3.busy, if3.pass});
        end
        @(posedge clk); #1;
        if3.start = 1'b0;
        checks++;
        if ({if3.busy, if3.valid, if3.done, if3.pass} !== 4'b1000) begin
            errors++; $display("FAIL b2b relaunch busy/valid/done/pass: got %b want 1000",
                               {if3.busy, if3.valid, if3.done, if3.pass});
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({if3.valid, if3.vec_out, if3.d_dual} !== {1'b1, 3'(i), ev[i]}) begin
                errors++; $display("FAIL b2b second vec%0d: got %b want %b", i,
                                   {if3.valid, if3.vec_out, if3.d_dual}, {1'b1, 3'(i), ev[i]});
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({if3.done, if3.pass, if3.mismatch_cnt} !== {1'b1, 1'b1, 4'd0}) begin
            errors++; $display("FAIL b2b second done/pass/cnt: got %b want 110000", {if3.done, if3.pass, if3.mismatch_cnt});
        end
        if3.mode = 1'b0;
    endtask

    // N=4, injection on the last vector.
    task automatic test_n4_inject_last();
        logic [15:0] ed;
        logic [15:0] eu;
        ed = 16'h807F;
        eu = 16'h007F;
        if4.start = 1'b1; if4.mode = 1'b0; if4.inj_en = 1'b1; if4.inj_vec = 4'd15;
        @(posedge clk); #1;
        if4.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({if4.valid, if4.vec_out, if4.d_direct, if4.d_dual, if4.done} !== {1'b1, 4'(i), ed[i], eu[i], 1'b0}) begin
                errors++; $display("FAIL n4 vec%0d valid/vec/dir/dual/done: got %b want %b", i,
                                   {if4.valid, if4.vec_out, if4.d_direct, if4.d_dual, if4.done}, {1'b1, 4'(i), ed[i], eu[i], 1'b0});
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({if4.done, if4.valid, if4.busy, if4.pass, if4.mismatch_cnt, if4.first_fail_vec} !== {4'b1000, 5'd1, 4'd15}) begin
            errors++; $display("FAIL n4 done/valid/busy/pass/cnt/ffv: got %b want %b",
                               {if4.done, if4.valid, if4.busy, if4.pass, if4.mismatch_cnt, if4.first_fail_vec}, {4'b1000, 5'd1, 4'd15});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_type1();
        test_type2();
        test_inject();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_n4_inject_last();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demorgan_sweep_checker.md
Name: demorgan_sweep_checker

Overview:
- Parametrised, sequential successor to the 3-input De Morgan gate. It generalises "type 1" and "type 2" De Morgan functions to N inputs.
- On request it sweeps all 2^N input vectors. For each vector it evaluates the direct (complemented-literal) form and the dual (complemented-sum/product) form, and compares them.
- It reports per-vector results, a mismatch count, the first failing vector and a pass flag.
- It is the lab self-check block: it sits beside the gate-level exercises and drives LEDs and the bench scoreboard.

Parameters:
- N, 3, number of gate inputs; legal range 2..16.
- CNT_W, N+1, width of mismatch counter; derived, not to be overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset; asserts immediately, releases synchronously to clk
- start  input  1  sweep request; sampled only in IDLE
- mode  input  1  0 = type 1, 1 = type 2; captured on accepted start
- inj_en  input  1  fault-injection enable; captured on accepted start
- inj_vec  input  N  vector at which d_direct is inverted when injection is enabled; captured on accepted start
- busy  output  1  high in SWEEP state
- valid  output  1  high while vec_out, d_direct and d_dual hold a swept vector
- vec_out  output  N  current vector; bit 0 = x[0]
- d_direct  output  1  direct-form result for vec_out (after injection)
- d_dual  output  1  dual-form result for vec_out
- done  output  1  one-cycle pulse at sweep completion
- pass  output  1  1 when the last completed sweep had zero mismatches; held until the next accepted start
- mismatch_cnt  output  CNT_W  number of mismatching vectors in the current or last sweep
- first_fail_vec  output  N  first mismatching vector; 0 if none

Behaviour:
- Functions, with P = x[N-2:0] and L = x[N-1]:
  - mode 0, direct: (|~P) & ~L
  - mode 0, dual: ~((&P) | L)
  - mode 1, direct: (&~P) | ~L
  - mode 1, dual: ~((|P) & L)
- Injection: d_direct is inverted when the captured inj_en = 1 and the counter equals the captured inj_vec.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, valid, done, pass, vec_out, d_direct, d_dual, mismatch_cnt and first_fail_vec all go to 0.
  - Captured mode/inj values and the internal counter are cleared.
- State machine:
  - IDLE -> SWEEP on start = 1. On that edge: capture mode/inj_en/inj_vec, set counter to 0, clear mismatch_cnt, first_fail_vec, pass and the fail flag. busy rises.
  - SWEEP: each edge registers counter, d_direct and d_dual into the outputs and sets valid = 1.
    - On mismatch: mismatch_cnt += 1 on the same edge. If no earlier fail this sweep, first_fail_vec <= counter and the fail flag is set.
    - Counter increments each edge.
    - When the registered counter = 2^N-1, the next state is DONE.
  - DONE (one cycle): valid = 0, busy = 0, done = 1, pass = ~fail flag. Next state is IDLE unconditionally.
- Timing: start accepted at edge k.
  - Vector i is on the outputs after edge k+1+i.
  - The last vector appears after edge k+2^N.
  - done is high after edge k+2^N+1, i.e. 2^N+1 cycles from start to done.
- start is ignored in SWEEP and DONE; no queuing.
- mode, inj_en and inj_vec changes during a sweep have no effect.
- Outputs vec_out, d_direct and d_dual hold their last values after the sweep; valid = 0 qualifies them.
- mismatch_cnt saturation is not needed: 2^N fits in CNT_W.
- Reset mid-sweep: immediate abort. No done pulse; all results cleared to 0.
- Back-to-back sweeps: start held high re-launches from IDLE on the edge after DONE.

Test Plan:
- N=3, mode=0, inj_en=0, start pulse: valid for 8 cycles; vec_out 0..7; d_direct = d_dual = 1,1,1,0,0,0,0,0; done 9 cycles after start; pass=1, mismatch_cnt=0, first_fail_vec=0.
- N=3, mode=1, inj_en=0: d_direct = d_dual = 1,1,1,1,1,0,0,0; pass=1, mismatch_cnt=0.
- N=3, mode=0, inj_en=1, inj_vec=5: vector 5 shows d_direct=1, d_dual=0; done with pass=0, mismatch_cnt=1, first_fail_vec=5.
- Pulse start again at vec_out=2 during a sweep, and change mode mid-sweep: no restart, sequence unchanged, exactly one done pulse.
- Drop rst_n when vec_out=3: all outputs 0 immediately, no done. A new start afterwards gives a clean 8-vector sweep.
- N=4, mode=0, inj_en=1, inj_vec=15: 16 valid cycles, done 17 cycles after start; at vec 15 d_direct=1, d_dual=0; mismatch_cnt=1, first_fail_vec=15, pass=0.
